// File: rtl/seq_scan_controller_if.sv
// Host/serial-source bundle for seq_scan_controller: config, control, serial bits and status.
interface seq_scan_controller_if #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned LENW   = 4,
  parameter int unsigned WINW   = 16,
  parameter int unsigned CNTW   = 16
);
  logic              start;
  logic              abort;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LENW-1:0]   cfg_len;
  logic              cfg_overlap;
  logic [WINW-1:0]   cfg_window;
  logic              bit_in;
  logic              bit_valid;
  logic              busy;
  logic              done;
  logic              match;
  logic [CNTW-1:0]   match_count;

  modport master (
    output start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_window, bit_in, bit_valid,
    input  busy, done, match, match_count
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_window, bit_in, bit_valid,
    output busy, done, match, match_count
  );
endinterface

// File: rtl/seq_scan_controller.sv
// Configurable serial pattern detector sequenced over a bounded scan window, counting matches.
module seq_scan_controller #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned LENW   = 4,
  parameter int unsigned WINW   = 16,
  parameter int unsigned CNTW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_scan_controller_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            r_state;
  logic [MAXLEN-1:0] r_pat;
  logic [LENW-1:0]   r_len;
  logic              r_overlap;
  logic [WINW-1:0]   r_win;
  // Only MAXLEN-1 bits need storing: the newest bit completes the post-shift history.
  logic [MAXLEN-2:0] r_hist;
  logic [LENW-1:0]   r_fill;
  logic [WINW-1:0]   r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_match;
  logic [CNTW-1:0]   r_count;

  logic [LENW-1:0]   w_len;
  logic [MAXLEN-1:0] w_hist_nx;
  logic [MAXLEN-1:0] w_mask;
  logic [LENW-1:0]   w_fill_nx;
  logic              w_accept;
  logic              w_hit;
  logic              w_last;

  always_comb begin
    w_len     = (r_len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : r_len;
    w_hist_nx = {r_hist, bus.bit_in};
    w_fill_nx = (r_fill >= LENW'(MAXLEN)) ? r_fill : r_fill + LENW'(1);
    w_accept  = (r_state == SCAN) && bus.bit_valid && (r_cnt < r_win);
    w_mask    = '0;
    for (int unsigned i = 0; i < MAXLEN; i++) begin
      if (i < 32'(w_len)) w_mask[i] = 1'b1;
    end
    w_hit  = w_accept && (w_len != '0) && (w_fill_nx >= w_len) &&
             (((w_hist_nx ^ r_pat) & w_mask) == '0);
    w_last = w_accept ? ((r_cnt + WINW'(1)) == r_win) : (r_cnt == r_win);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_win     <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_match <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_pat     <= bus.cfg_pattern;
            r_len     <= bus.cfg_len;
            r_overlap <= bus.cfg_overlap;
            r_win     <= bus.cfg_window;
            r_hist    <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          if (w_accept) begin
            r_hist <= w_hist_nx[MAXLEN-2:0];
            r_cnt  <= r_cnt + WINW'(1);
            r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_nx;
          end
          if (w_hit) begin
            r_match <= 1'b1;
            if (!(&r_count)) r_count <= r_count + CNTW'(1);
          end
          // Abort takes priority over completion so an aborted scan never reports done.
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.match       = r_match;
  assign bus.match_count = r_count;

endmodule

// File: tb/tb_seq_scan_controller.sv
// Directed bench for seq_scan_controller with a match-expectation scoreboard queue.
module tb_seq_scan_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_scan_controller_if #(.MAXLEN(8), .LENW(4), .WINW(16), .CNTW(16)) ifa ();
  seq_scan_controller_if #(.MAXLEN(8), .LENW(4), .WINW(16), .CNTW(2))  ifb ();

  seq_scan_controller #(.MAXLEN(8), .LENW(4), .WINW(16), .CNTW(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  seq_scan_controller #(.MAXLEN(8), .LENW(4), .WINW(16), .CNTW(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get(input bit sel, input int unsigned which);
    logic [31:0] v;
    v = '0;
    case (which)
      0: v = sel ? 32'(ifb.busy)        : 32'(ifa.busy);
      1: v = sel ? 32'(ifb.done)        : 32'(ifa.done);
      2: v = sel ? 32'(ifb.match)       : 32'(ifa.match);
      default: v = sel ? 32'(ifb.match_count) : 32'(ifa.match_count);
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input bit sel, input logic [7:0] pat, input logic [3:0] len,
                     input logic ov, input logic [15:0] win);
    if (sel) begin
      ifb.cfg_pattern = pat; ifb.cfg_len = len; ifb.cfg_overlap = ov; ifb.cfg_window = win;
    end else begin
      ifa.cfg_pattern = pat; ifa.cfg_len = len; ifa.cfg_overlap = ov; ifa.cfg_window = win;
    end
  endtask

  task automatic start_scan(input bit sel);
    if (sel) ifb.start = 1'b1; else ifa.start = 1'b1;
    tick();
    if (sel) ifb.start = 1'b0; else ifa.start = 1'b0;
  endtask

  // One cycle of serial input; an accepted bit pushes its expected match onto the queue.
  task automatic feed(input bit sel, input logic v, input logic b, input logic em, input logic ed);
    logic exp_m;
    if (v) exp_q.push_back(em);
    if (sel) begin ifb.bit_valid = v; ifb.bit_in = b; end
    else     begin ifa.bit_valid = v; ifa.bit_in = b; end
    tick();
    if (sel) ifb.bit_valid = 1'b0; else ifa.bit_valid = 1'b0;
    exp_m = 1'b0;
    if (v) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
      else exp_m = exp_q.pop_front();
    end
    chk("match", get(sel, 2), 32'(exp_m));
    chk("done", get(sel, 1), 32'(ed));
  endtask

  initial begin
    logic [5:0] t3_bits;
    logic [5:0] t3_em;
    t3_bits = 6'b110110; // bit i is the i-th serial bit: 0,1,1,0,1,1
    t3_em   = 6'b001000;

    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.bit_in = 1'b0; ifa.bit_valid = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.bit_in = 1'b0; ifb.bit_valid = 1'b0;
    cfg(0, 8'h00, 4'd0, 1'b0, 16'd0);
    cfg(1, 8'h00, 4'd0, 1'b0, 16'd0);

    #12;
    chk("rst_busy",  get(0, 0), 32'd0);
    chk("rst_done",  get(0, 1), 32'd0);
    chk("rst_match", get(0, 2), 32'd0);
    chk("rst_count", get(0, 3), 32'd0);
    chk("rst_count_b", get(1, 3), 32'd0);
    rst = 1'b1;

    // 101 overlapping, window 5
    cfg(0, 8'b101, 4'd3, 1'b1, 16'd5);
    start_scan(0);
    chk("t1_busy", get(0, 0), 32'd1);
    chk("t1_count0", get(0, 3), 32'd0);
    feed(0, 1, 1, 0, 0);
    feed(0, 1, 0, 0, 0);
    feed(0, 1, 1, 1, 0);
    feed(0, 1, 0, 0, 0);
    feed(0, 1, 1, 1, 1);
    chk("t1_count", get(0, 3), 32'd2);
    chk("t1_busy_done", get(0, 0), 32'd0);
    tick();
    chk("t1_done_1cyc", get(0, 1), 32'd0);
    chk("t1_count_hold", get(0, 3), 32'd2);

    // 101 non-overlapping
    cfg(0, 8'b101, 4'd3, 1'b0, 16'd5);
    start_scan(0);
    feed(0, 1, 1, 0, 0);
    feed(0, 1, 0, 0, 0);
    feed(0, 1, 1, 1, 0);
    feed(0, 1, 0, 0, 0);
    feed(0, 1, 1, 0, 1);
    chk("t2_count", get(0, 3), 32'd1);
    tick();

    // 0110 with valid gaps and a mid-scan config change
    cfg(0, 8'b0110, 4'd4, 1'b1, 16'd6);
    start_scan(0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) cfg(0, 8'b1011, 4'd4, 1'b0, 16'd3);
      feed(0, 1, t3_bits[i], t3_em[i], (i == 5));
      if (i < 5) feed(0, 0, 1, 0, 0);
    end
    chk("t3_count", get(0, 3), 32'd1);
    tick();
    // bit_valid in IDLE is ignored
    feed(0, 0, 1, 0, 0);
    ifa.bit_valid = 1'b1; ifa.bit_in = 1'b1;
    tick();
    ifa.bit_valid = 1'b0;
    chk("idle_bits_match", get(0, 2), 32'd0);
    chk("idle_bits_count", get(0, 3), 32'd1);

    // window 0, start held high through SCAN
    cfg(0, 8'b101, 4'd3, 1'b1, 16'd0);
    ifa.start = 1'b1;
    tick();
    chk("t4_busy", get(0, 0), 32'd1);
    chk("t4_nodone", get(0, 1), 32'd0);
    chk("t4_count_clr", get(0, 3), 32'd0);
    tick();
    chk("t4_done", get(0, 1), 32'd1);
    chk("t4_busy_low", get(0, 0), 32'd0);
    chk("t4_count", get(0, 3), 32'd0);
    ifa.start = 1'b0;
    tick();
    chk("t4_done_end", get(0, 1), 32'd0);
    chk("t4_idle", get(0, 0), 32'd0);

    // CNTW=2 saturation
    cfg(1, 8'b1, 4'd1, 1'b1, 16'd6);
    start_scan(1);
    for (int i = 0; i < 6; i++) feed(1, 1, 1, 1, (i == 5));
    chk("t5_sat", get(1, 3), 32'd3);

    // abort after 3 of 5 bits
    cfg(0, 8'b101, 4'd3, 1'b1, 16'd5);
    start_scan(0);
    feed(0, 1, 1, 0, 0);
    feed(0, 1, 0, 0, 0);
    feed(0, 1, 1, 1, 0);
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk("t6_busy", get(0, 0), 32'd0);
    chk("t6_done", get(0, 1), 32'd0);
    chk("t6_count", get(0, 3), 32'd1);
    tick();
    chk("t6_done_later", get(0, 1), 32'd0);
    chk("t6_count_hold", get(0, 3), 32'd1);

    // asynchronous reset mid-scan
    start_scan(0);
    feed(0, 1, 1, 0, 0);
    feed(0, 1, 0, 0, 0);
    feed(0, 1, 1, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_busy", get(0, 0), 32'd0);
    chk("t7_done", get(0, 1), 32'd0);
    chk("t7_match", get(0, 2), 32'd0);
    chk("t7_count", get(0, 3), 32'd0);
    #3;
    rst = 1'b1;
    tick();
    chk("t7_stay_idle", get(0, 0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_scan_controller.md
Name: seq_scan_controller

Overview:
- Sequences a programmable serial pattern detector over a bounded scan window and counts the matches.
- Host loads pattern, length, overlap mode and window length, then pulses start. The block consumes valid-qualified serial bits, pulses match per detection, and reports done with a final match count.
- Sits between the serial bit source and the host/status logic. Generalises the fixed 101 detectors into one configurable, sequenced scan engine.

Parameters:
- MAXLEN, 8: maximum pattern length in bits.
- LENW, 4: width of cfg_len. Must be at least clog2(MAXLEN)+1.
- WINW, 16: width of the scan window bit counter.
- CNTW, 16: width of match_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin scan; sampled only in IDLE.
- abort  in  1  terminate scan; sampled in SCAN.
- cfg_pattern  in  MAXLEN  pattern; bit [cfg_len-1] is the first serial bit, bit 0 the last.
- cfg_len  in  LENW  pattern length in bits.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_window  in  WINW  number of bits to accept before done.
- bit_in  in  1  serial data.
- bit_valid  in  1  bit_in is valid this cycle.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse at normal scan completion.
- match  out  1  one-cycle pulse per detection.
- match_count  out  CNTW  matches in the current/last scan.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, match=0, match_count=0; history, fill and bit counters cleared.
- FSM has three states: IDLE, SCAN, DONE.
- IDLE to SCAN when start=1.
  - On that edge, capture cfg_* into internal registers. Config changes during a scan have no effect.
  - Clear match_count, history, fill counter and accepted-bit counter.
- SCAN:
  - A bit is accepted when bit_valid=1 and accepted count < captured window.
  - Accepted bits shift into history LSB-first-arrival-oldest: hist <= {hist[MAXLEN-2:0], bit_in}.
  - fill increments, saturating at MAXLEN.
- Detection is evaluated on the post-shift history. A hit requires len != 0, fill >= len, and the low len bits of history equal the low len bits of the pattern.
- Effective len = min(cfg_len, MAXLEN). len=0 never matches.
- On a hit:
  - match=1 the cycle after the accepting edge (registered, 1-cycle latency).
  - match_count increments, saturating at all-ones.
  - Non-overlap mode: fill is cleared on the same edge, so the next hit needs len fresh bits.
  - Overlap mode: fill is unchanged.
- SCAN to DONE on the edge where accepted count reaches window, i.e. the last bit accepted or window=0.
  - window=0: DONE is entered on the first SCAN edge with no bits accepted.
  - A hit on the final bit gives match=1 in the same cycle as done=1.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE. match_count holds until the next start.
- abort=1 in SCAN: go to IDLE next edge; no done pulse; match_count retains its partial value. A bit accepted on the same edge still counts. abort has no effect in IDLE or DONE.
- start while in SCAN or DONE is ignored.
- bit_valid outside SCAN is ignored.
- rst asserted mid-scan: immediate return to the reset values.

Test Plan:
- Pattern 101, len 3, overlap=1, window 5, bits 1,0,1,0,1 one per cycle: match pulses after bits 3 and 5, done with match_count=2, match and done coincide on the last bit.
- Same setup with overlap=0: single match after bit 3, match_count=1.
- Pattern 0110, len 4, window 6, bit_valid toggling 1/0, bits 0,1,1,0,1,1: gaps do not break detection, one match, done after the 6th accepted bit; cfg change mid-scan has no effect.
- window=0, start: busy for one cycle, done next, match_count=0. start during SCAN is ignored.
- CNTW=2, pattern 1, len 1, window 6, all ones: match_count saturates at 3, done after 6 bits.
- abort after 3 of 5 bits with 1 match: IDLE, no done, match_count=1. Repeat scan with rst=0 mid-scan: all outputs 0 immediately.
